// File: rtl/app_mem_resp.sv
// Responder for the 128-bit app memory interface: byte-masked block-RAM lines with fixed-latency reads.
// Optional macro APP_MEM_RESP_STALL_EN adds LFSR-driven backpressure on app_rdy / app_wdf_rdy.
module app_mem_resp #(
  parameter int DEPTH_LOG2   = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [27:0]  app_addr,
  input  logic [2:0]   app_cmd,
  input  logic         app_en,
  output logic         app_rdy,
  input  logic [127:0] app_wdf_data,
  input  logic [15:0]  app_wdf_mask,
  input  logic         app_wdf_wren,
  input  logic         app_wdf_end,
  output logic         app_wdf_rdy,
  output logic [127:0] app_rd_data,
  output logic         app_rd_data_valid,
  output logic         app_rd_data_end
);

  typedef enum logic [1:0] {S_RESET, S_IDLE, S_WAIT_WDATA} state_t;

  state_t                  state, state_nxt;
  logic [127:0]            mem [0:(1<<DEPTH_LOG2)-1];
  logic                    wbuf_full;
  logic [127:0]            wbuf_dat;
  logic [15:0]             wbuf_msk;
  logic [DEPTH_LOG2-1:0]   wait_idx;
  logic [READ_LATENCY-1:0] rd_vld;
  logic [127:0]            rd_dat [READ_LATENCY];
  logic                    stall_cmd, stall_wd;
  logic                    cmd_acc, wd_acc, rd_acc;
  logic                    we, buf_load, buf_clr, cap_idx;
  logic [DEPTH_LOG2-1:0]   widx;
  logic [127:0]            wdat;
  logic [15:0]             wmsk;
  logic                    unused;

  assign unused = ^{app_wdf_end, app_addr[27:DEPTH_LOG2]};

`ifdef APP_MEM_RESP_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall_cmd = lfsr[0];
  assign stall_wd  = lfsr[1];
`else
  assign stall_cmd = 1'b0;
  assign stall_wd  = 1'b0;
`endif

  assign app_rdy     = (state == S_IDLE) && !stall_cmd;
  assign app_wdf_rdy = (state != S_RESET) && !wbuf_full && !stall_wd;
  assign cmd_acc     = app_en && app_rdy;
  assign wd_acc      = app_wdf_wren && app_wdf_rdy;
  assign rd_acc      = cmd_acc && (app_cmd == 3'b001);

  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    buf_load  = 1'b0;
    buf_clr   = 1'b0;
    cap_idx   = 1'b0;
    widx      = app_addr[DEPTH_LOG2-1:0];
    wdat      = app_wdf_data;
    wmsk      = app_wdf_mask;
    case (state)
      S_RESET: state_nxt = S_IDLE;
      S_IDLE: begin
        if (cmd_acc && app_cmd == 3'b000) begin
          if (wbuf_full) begin
            we      = 1'b1;
            wdat    = wbuf_dat;
            wmsk    = wbuf_msk;
            buf_clr = 1'b1;
          end else if (wd_acc) begin
            we = 1'b1;
          end else begin
            cap_idx   = 1'b1;
            state_nxt = S_WAIT_WDATA;
          end
        end else if (wd_acc) begin
          // data arrived ahead of its command: park it
          buf_load = 1'b1;
        end
      end
      S_WAIT_WDATA: begin
        widx = wait_idx;
        if (wd_acc) begin
          we        = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_RESET;
      wbuf_full <= 1'b0;
      wbuf_dat  <= '0;
      wbuf_msk  <= '0;
      wait_idx  <= '0;
    end else begin
      state <= state_nxt;
      if (buf_load) begin
        wbuf_full <= 1'b1;
        wbuf_dat  <= app_wdf_data;
        wbuf_msk  <= app_wdf_mask;
      end else if (buf_clr) begin
        wbuf_full <= 1'b0;
      end
      if (cap_idx) wait_idx <= app_addr[DEPTH_LOG2-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 16; b++) begin
        if (wmsk[b]) mem[widx][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
  end

  // Memory is sampled at acceptance so later writes never leak into an in-flight read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) rd_dat[i] <= '0;
    end else begin
      rd_vld[0] <= rd_acc;
      if (rd_acc) rd_dat[0] <= mem[app_addr[DEPTH_LOG2-1:0]];
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_vld[i] <= rd_vld[i-1];
        if (rd_vld[i-1]) rd_dat[i] <= rd_dat[i-1];
      end
    end
  end

  assign app_rd_data       = rd_dat[READ_LATENCY-1];
  assign app_rd_data_valid = rd_vld[READ_LATENCY-1];
  assign app_rd_data_end   = rd_vld[READ_LATENCY-1];

endmodule

// File: tb/tb_app_mem_resp.sv
// Scoreboard bench for app_mem_resp (default build, READ_LATENCY=2, DEPTH_LOG2=10).
module tb_app_mem_resp;

  logic         clk, reset;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en, app_rdy;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid, app_rd_data_end;

  app_mem_resp dut (
    .clk(clk), .reset(reset), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_rdy(app_rdy), .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end)
  );

  typedef struct {
    logic [127:0] dat;
    int           cyc;
    bit           chk_dat;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] model [1024];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  bit           pend_vld = 0, wait_vld = 0;
  logic [127:0] pend_d;
  logic [15:0]  pend_m;
  logic [27:0]  wait_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void commit(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m);
    for (int b = 0; b < 16; b++)
      if (m[b]) model[a[9:0]][8*b +: 8] = d[8*b +: 8];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && app_rd_data_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 128'(1), 128'(0));
      end else begin
        e = sb.pop_front();
        chk("rd_latency", 128'(cyc), 128'(e.cyc));
        chk("rd_end", 128'(app_rd_data_end), 128'(1));
        if (e.chk_dat) chk("rd_data", app_rd_data, e.dat);
      end
    end
  end

  task automatic wait_rdy(input bit need_cmd, input bit need_wd, output bit ok);
    int n = 0;
    ok = 0;
    while (n < 50) begin
      if ((!need_cmd || app_rdy) && (!need_wd || app_wdf_rdy)) begin
        ok = 1;
        break;
      end
      @(negedge clk);
      n++;
    end
    if (!ok) chk("handshake_timeout", 128'(0), 128'(1));
  endtask

  task automatic idle(input int n);
    app_en = 0;
    app_wdf_wren = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [27:0] a);
    bit ok;
    exp_t e;
    app_en = 1; app_cmd = 3'b001; app_addr = a; app_wdf_wren = 0;
    wait_rdy(1, 0, ok);
    if (ok) begin
      e.dat = model[a[9:0]]; e.cyc = cyc + 2; e.chk_dat = 1;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic wr_both(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m);
    bit ok;
    app_en = 1; app_cmd = 3'b000; app_addr = a;
    app_wdf_wren = 1; app_wdf_data = d; app_wdf_mask = m;
    wait_rdy(1, 1, ok);
    if (ok) commit(a, d, m);
    @(negedge clk);
    app_wdf_wren = 0;
  endtask

  task automatic wr_cmd(input logic [27:0] a);
    bit ok;
    app_en = 1; app_cmd = 3'b000; app_addr = a; app_wdf_wren = 0;
    wait_rdy(1, 0, ok);
    if (ok) begin
      if (pend_vld) begin
        commit(a, pend_d, pend_m);
        pend_vld = 0;
      end else begin
        wait_vld = 1;
        wait_a = a;
      end
    end
    @(negedge clk);
    app_en = 0;
  endtask

  task automatic wd_only(input logic [127:0] d, input logic [15:0] m);
    bit ok;
    app_en = 0; app_wdf_wren = 1; app_wdf_data = d; app_wdf_mask = m;
    wait_rdy(0, 1, ok);
    if (ok) begin
      if (wait_vld) begin
        commit(wait_a, d, m);
        wait_vld = 0;
      end else begin
        pend_vld = 1; pend_d = d; pend_m = m;
      end
    end
    @(negedge clk);
    app_wdf_wren = 0;
  endtask

  initial begin
    exp_t e;
    reset = 1; app_en = 1; app_cmd = 3'b001; app_addr = 0;
    app_wdf_wren = 0; app_wdf_data = 0; app_wdf_mask = 0; app_wdf_end = 0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 128'(app_rdy), 128'(0));
    chk("rst_wdf_rdy", 128'(app_wdf_rdy), 128'(0));
    chk("rst_valid", 128'(app_rd_data_valid), 128'(0));
    chk("rst_end", 128'(app_rd_data_end), 128'(0));
    chk("rst_rd_data", app_rd_data, 128'(0));

    // release with a read already requested: rdy low for one cycle, then high
    reset = 0;
    chk("rdy_first_cycle", 128'(app_rdy), 128'(0));
    @(negedge clk);
    chk("rdy_second_cycle", 128'(app_rdy), 128'(1));
    e.dat = '0; e.cyc = cyc + 2; e.chk_dat = 0;
    sb.push_back(e);
    @(negedge clk);
    idle(4);

    wr_both(28'h5, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 16'hFFFF);
    rd(28'h5);
    idle(4);

    // data before command parks in the one-entry buffer
    wd_only(128'hA5, 16'h0001);
    chk("wbuf_full_rdy", 128'(app_wdf_rdy), 128'(0));
    idle(2);
    chk("wbuf_still_full", 128'(app_wdf_rdy), 128'(0));
    wr_cmd(28'h5);
    chk("wbuf_drained", 128'(app_wdf_rdy), 128'(1));
    rd(28'h5);
    idle(4);

    // command before data stalls the command port
    wr_cmd(28'h7);
    repeat (3) begin
      chk("wait_wdata_rdy", 128'(app_rdy), 128'(0));
      @(negedge clk);
    end
    wd_only({4{32'hC0DE_0007}}, 16'hFFFF);
    chk("rdy_after_wdata", 128'(app_rdy), 128'(1));
    rd(28'h7);
    idle(4);

    for (int i = 0; i < 4; i++)
      wr_both(28'(i), {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
    for (int i = 0; i < 4; i++) rd(28'(i));
    rd(28'h400);
    idle(5);

    wr_both(28'h3, {$urandom, $urandom, $urandom, $urandom}, 16'h0F0F);
    wr_both(28'h3, {$urandom, $urandom, $urandom, $urandom}, 16'hF000);
    rd(28'h3);
    rd(28'hFFF_FC03);
    idle(5);

    // illegal command: handshake completes, nothing else happens
    app_en = 1; app_cmd = 3'b010; app_addr = 28'h5; app_wdf_wren = 0;
    @(negedge clk);
    chk("illegal_accepted", 128'(app_rdy), 128'(1));
    app_en = 0;
    idle(4);
    rd(28'h5);
    idle(4);

    // reset with buffered data and reads in flight
    wd_only({4{32'hDEAD_BEEF}}, 16'hFFFF);
    rd(28'h1);
    app_addr = 28'h2;
    @(posedge clk);
    #1;
    reset = 1;
    app_en = 0;
    sb.delete();
    pend_vld = 0;
    wait_vld = 0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_valid", 128'(app_rd_data_valid), 128'(0));
      chk("midrst_rd_data", app_rd_data, 128'(0));
    end
    reset = 0;
    repeat (4) begin
      @(negedge clk);
      chk("postrst_valid", 128'(app_rd_data_valid), 128'(0));
    end
    wr_cmd(28'h9);
    chk("rst_wbuf_dropped", 128'(app_rdy), 128'(0));
    wd_only({4{32'h9999_0009}}, 16'hFFFF);
    rd(28'h9);
    rd(28'h5);
    idle(6);

    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/app_mem_resp.md
Name: app_mem_resp

Overview:
- Responder end of the 128-bit app memory interface that sys_ctrl and the core drive as initiators.
- Accepts read and write commands and stores 128-bit lines in on-chip block RAM.
- Returns read data after a fixed pipeline latency.
- Serves as the simulation/FPGA stand-in for the external DDR controller behind the mem_bus_ctrl mux.

Parameters:
- DEPTH_LOG2, 10, log2 of the number of 128-bit lines stored; only app_addr[DEPTH_LOG2-1:0] indexes memory.
- READ_LATENCY, 2, cycles from read-command acceptance to app_rd_data_valid; legal range 1..4.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- app_addr  in  28  quad-word (line) address.
- app_cmd  in  3  000 = write, 001 = read, others = illegal.
- app_en  in  1  command request; transfers when app_en && app_rdy.
- app_rdy  out  1  command accepted this cycle if app_en.
- app_wdf_data  in  128  write data.
- app_wdf_mask  in  16  byte enables; bit i = 1 writes byte i (bits [8i+7:8i]).
- app_wdf_wren  in  1  write data valid; transfers when app_wdf_wren && app_wdf_rdy.
- app_wdf_end  in  1  last beat; always single-beat, ignored.
- app_wdf_rdy  out  1  write data accepted this cycle if app_wdf_wren.
- app_rd_data  out  128  read data.
- app_rd_data_valid  out  1  app_rd_data valid, one cycle per read.
- app_rd_data_end  out  1  equals app_rd_data_valid (single beat).

Behaviour:
- Reset (async): state=S_RESET, write-data buffer empty, read pipeline valid bits cleared, app_rd_data=0. app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end are 0. Memory contents are not affected by reset.
- FSM states:
  - S_RESET: always goes to S_IDLE on the next cycle.
  - S_IDLE: app_rdy=1.
  - S_WAIT_WDATA: app_rdy=0; holds the captured write line index.
- app_wdf_rdy = (state != S_RESET) && !wbuf_full.
- The write-data buffer is one entry (data and mask). It fills when data is accepted without a write being committed in the same cycle.
- Write command accepted in S_IDLE. The write commits at that clock edge and the FSM stays in S_IDLE if either:
  - wbuf_full: commit from the buffer and empty it, or
  - app_wdf_wren && !wbuf_full: commit directly from the bus.
  Otherwise capture the index and go to S_WAIT_WDATA.
- In S_WAIT_WDATA, accepted write data commits to the captured index and the FSM returns to S_IDLE.
- Write commit updates only the bytes whose mask bit is 1.
- Read command accepted in S_IDLE: the line index enters a READ_LATENCY-stage pipeline. Valid is asserted exactly READ_LATENCY cycles after acceptance, and app_rd_data updates in that cycle. Back-to-back reads are accepted every cycle; responses return in order.
- app_rd_data holds its last value while valid=0.
- Ordering:
  - A read accepted in any cycle after a write commit returns the new data.
  - Only one command transfers per cycle, so a read and a write cannot collide.
- Reads are accepted while write data sits in the buffer and do not consume it.
- Illegal app_cmd values are accepted (app_rdy handshake completes) and discarded: no memory change, no response.
- Address aliasing: app_addr[27:DEPTH_LOG2] is ignored, so addresses wrap modulo 2^DEPTH_LOG2 lines.
- Reset mid-operation:
  - In-flight reads are dropped; no valid pulse appears after reset.
  - A pending S_WAIT_WDATA write is abandoned.
  - Buffered write data is discarded.

Optional Feature:
- Macro: APP_MEM_RESP_STALL_EN.
- Defined: a 16-bit LFSR (seed 16'hACE1 on reset, x^16+x^14+x^13+x^11, advancing every cycle) gates the ready outputs.
  - app_rdy is additionally forced to 0 when lfsr[0]=1.
  - app_wdf_rdy is additionally forced to 0 when lfsr[1]=1.
  - This exercises initiator backpressure; all ordering and commit rules are unchanged.
- Undefined: no LFSR is built; the readies follow the rules above only.

Test Plan:
- Release reset; hold app_en=1, app_cmd=001 -> app_rdy=0 in the first cycle, 1 in the second. The first valid appears READ_LATENCY=2 cycles after the first accepted read.
- Write cmd addr 0x5 with same-cycle wren, data 128'h0123_..._CDEF, mask 16'hFFFF; read addr 0x5 next cycle -> app_rd_data equals the written data, valid and end high exactly 2 cycles after the read is accepted.
- Write data first (mask 16'h0001, data byte 0 = 8'hA5) with no cmd -> app_wdf_rdy drops to 0. Write cmd to addr 0x5 two cycles later -> buffer drains. Read addr 0x5 -> byte 0 = 8'hA5, bytes 1..15 unchanged.
- Write cmd to addr 0x7 without data -> app_rdy=0 (S_WAIT_WDATA) until wren. Then the line commits and app_rdy returns to 1 the next cycle.
- Reads issued back-to-back to addrs 0,1,2,3 -> four consecutive valid cycles, data in order. Read of addr 0x400 with DEPTH_LOG2=10 -> returns line 0.
- Issue 2 reads, assert reset one cycle later -> no app_rd_data_valid after reset, app_rd_data=0. app_cmd=3'b010 -> accepted, no response, memory unchanged.
